// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: feeds lcd_driver one 9-bit word at a time.
// Plays a fixed power-up ROM, then serves full-frame writes (window set + RGB565 pixels).
// Optional feature macro: LCD_SEQ_DELAY_EN. When defined, ROM DELAY entries wait
// payload*DELAY_UNIT cycles. When undefined, DELAY entries are skipped in one cycle.
module lcd_cmd_sequencer #(
    parameter int unsigned H_RES      = 128,
    parameter int unsigned V_RES      = 160,
    parameter int unsigned DELAY_UNIT = 1000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_init,
    output logic        init_done,
    input  logic        frame_req,
    output logic        frame_busy,
    output logic        frame_done,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic        drv_valid,
    output logic        drv_index_or_data,
    output logic [8:0]  drv_data,
    input  logic        drv_done
);

    localparam int unsigned NumPix  = H_RES * V_RES;
    localparam int unsigned PixW    = (NumPix > 1) ? $clog2(NumPix) : 1;
    localparam logic [PixW-1:0] PixLast = PixW'(NumPix - 1);
    localparam logic [7:0] ColEnd   = 8'(H_RES - 1);
    localparam logic [7:0] RowEnd   = 8'(V_RES - 1);
    localparam logic [3:0] WinLast  = 4'd10;

    localparam logic [1:0] TyIndex = 2'b00;
    localparam logic [1:0] TyData  = 2'b01;
    localparam logic [1:0] TyDelay = 2'b10;

    typedef enum logic [3:0] {
        StIdle, StRomFetch, StIssue, StWaitDone, StDelay, StReady, StPixIn, StPixHi, StPixLo
    } state_e;

    // Return tag: where WAIT_DONE goes once the current word completes.
    typedef enum logic [1:0] {TagRom, TagWin, TagPixHi, TagPixLo} tag_e;

    // Power-up ROM: {type[1:0], payload[7:0]}.
    function automatic logic [9:0] rom_entry(input logic [3:0] idx);
        logic [9:0] e;
        case (idx)
            4'd0:    e = {TyIndex, 8'h01};
            4'd1:    e = {TyDelay, 8'd150};
            4'd2:    e = {TyIndex, 8'h11};
            4'd3:    e = {TyDelay, 8'd255};
            4'd4:    e = {TyIndex, 8'h3A};
            4'd5:    e = {TyData,  8'h05};
            4'd6:    e = {TyIndex, 8'h36};
            4'd7:    e = {TyData,  8'hC8};
            4'd8:    e = {TyIndex, 8'h29};
            default: e = 10'h3FF;  // END
        endcase
        return e;
    endfunction

    // Window-set words: {D/C, byte}.
    function automatic logic [8:0] win_word(input logic [3:0] idx);
        logic [8:0] w;
        case (idx)
            4'd0:    w = {1'b0, 8'h2A};
            4'd4:    w = {1'b1, ColEnd};
            4'd5:    w = {1'b0, 8'h2B};
            4'd9:    w = {1'b1, RowEnd};
            4'd10:   w = {1'b0, 8'h2C};
            default: w = {1'b1, 8'h00};
        endcase
        return w;
    endfunction

    state_e          state_q, state_d;
    tag_e            tag_q, tag_d;
    logic [8:0]      word_q, word_d;
    logic [3:0]      rom_ptr_q, rom_ptr_d;
    logic [3:0]      win_idx_q, win_idx_d;
    logic [15:0]     pix_q, pix_d;
    logic [PixW-1:0] pix_cnt_q, pix_cnt_d;
    logic            init_done_q, init_done_d;
    logic            frame_busy_q, frame_busy_d;
    logic            frame_done_q, frame_done_d;
    logic [9:0]      rom_ent;

    assign rom_ent = rom_entry(rom_ptr_q);

`ifdef LCD_SEQ_DELAY_EN
    localparam int unsigned DlyBits = $clog2(255 * DELAY_UNIT + 1);
    localparam int unsigned DlyW    = (DlyBits > 16) ? DlyBits : 16;
    logic [DlyW-1:0] dly_q, dly_d;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            tag_q        <= TagRom;
            word_q       <= '0;
            rom_ptr_q    <= '0;
            win_idx_q    <= '0;
            pix_q        <= '0;
            pix_cnt_q    <= '0;
            init_done_q  <= 1'b0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef LCD_SEQ_DELAY_EN
            dly_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            word_q       <= word_d;
            rom_ptr_q    <= rom_ptr_d;
            win_idx_q    <= win_idx_d;
            pix_q        <= pix_d;
            pix_cnt_q    <= pix_cnt_d;
            init_done_q  <= init_done_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
`ifdef LCD_SEQ_DELAY_EN
            dly_q        <= dly_d;
`endif
        end
    end

    // Next-state logic: ROM playback, window words, pixel bytes, shared ISSUE/WAIT_DONE.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        word_d       = word_q;
        rom_ptr_d    = rom_ptr_q;
        win_idx_d    = win_idx_q;
        pix_d        = pix_q;
        pix_cnt_d    = pix_cnt_q;
        init_done_d  = init_done_q;
        frame_busy_d = frame_busy_q;
        frame_done_d = 1'b0;
`ifdef LCD_SEQ_DELAY_EN
        dly_d        = dly_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_init) begin
                    rom_ptr_d = '0;
                    state_d   = StRomFetch;
                end
            end
            StRomFetch: begin
                case (rom_ent[9:8])
                    TyIndex, TyData: begin
                        // type bit 0 doubles as the D/C bit
                        word_d  = rom_ent[8:0];
                        tag_d   = TagRom;
                        state_d = StIssue;
                    end
                    TyDelay: begin
`ifdef LCD_SEQ_DELAY_EN
                        dly_d   = DlyW'(rom_ent[7:0]) * DlyW'(DELAY_UNIT);
                        state_d = StDelay;
`else
                        rom_ptr_d = rom_ptr_q + 4'd1;
`endif
                    end
                    default: begin
                        init_done_d = 1'b1;
                        state_d     = StReady;
                    end
                endcase
            end
            StIssue: state_d = StWaitDone;
            StWaitDone: begin
                if (drv_done) begin
                    case (tag_q)
                        TagRom: begin
                            rom_ptr_d = rom_ptr_q + 4'd1;
                            state_d   = StRomFetch;
                        end
                        TagWin: begin
                            if (win_idx_q == WinLast) begin
                                state_d = StPixIn;
                            end else begin
                                win_idx_d = win_idx_q + 4'd1;
                                word_d    = win_word(win_idx_q + 4'd1);
                                state_d   = StIssue;
                            end
                        end
                        TagPixHi: state_d = StPixLo;
                        default: begin
                            if (pix_cnt_q == PixLast) begin
                                frame_busy_d = 1'b0;
                                frame_done_d = 1'b1;
                                state_d      = StReady;
                            end else begin
                                pix_cnt_d = pix_cnt_q + PixW'(1);
                                state_d   = StPixIn;
                            end
                        end
                    endcase
                end
            end
`ifdef LCD_SEQ_DELAY_EN
            StDelay: begin
                // Payload 0 loads 0 and still spends exactly one cycle here.
                if (dly_q <= DlyW'(1)) begin
                    rom_ptr_d = rom_ptr_q + 4'd1;
                    state_d   = StRomFetch;
                end else begin
                    dly_d = dly_q - DlyW'(1);
                end
            end
`endif
            StReady: begin
                if (frame_req) begin
                    frame_busy_d = 1'b1;
                    win_idx_d    = '0;
                    pix_cnt_d    = '0;
                    word_d       = win_word(4'd0);
                    tag_d        = TagWin;
                    state_d      = StIssue;
                end
            end
            StPixIn: begin
                if (pix_valid) begin
                    pix_d   = pix_data;
                    state_d = StPixHi;
                end
            end
            StPixHi: begin
                word_d  = {1'b1, pix_q[15:8]};
                tag_d   = TagPixHi;
                state_d = StIssue;
            end
            StPixLo: begin
                word_d  = {1'b1, pix_q[7:0]};
                tag_d   = TagPixLo;
                state_d = StIssue;
            end
            default: state_d = StIdle;
        endcase
    end

    assign drv_valid         = (state_q == StIssue);
    assign pix_ready         = (state_q == StPixIn);
    assign drv_data          = word_q;
    assign drv_index_or_data = word_q[8];
    assign init_done         = init_done_q;
    assign frame_busy        = frame_busy_q;
    assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with a behavioural driver responder.
module tb_lcd_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_init = 1'b0;
    logic        frame_req = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        drv_done = 1'b0;
    logic        init_done, frame_busy, frame_done, pix_ready;
    logic        drv_valid, drv_index_or_data;
    logic [8:0]  drv_data;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    logic [8:0] wlog[$];
    int vt[$];
    int dt[$];
    int ovl = 0;
    int unstable = 0;
    int dc_err = 0;
    int fd_cnt = 0;
    int init_t = -1;
    logic inject_done = 1'b0;

    logic [8:0] rom_exp [7] = '{9'h001, 9'h011, 9'h03A, 9'h105, 9'h036, 9'h1C8, 9'h029};
    logic [8:0] frm_exp [19] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
                                 9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C,
                                 9'h112, 9'h134, 9'h1AB, 9'h1CD, 9'h100, 9'h100,
                                 9'h1FF, 9'h1FF};

    lcd_cmd_sequencer #(.H_RES(2), .V_RES(2), .DELAY_UNIT(4)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .start_init        (start_init),
        .init_done         (init_done),
        .frame_req         (frame_req),
        .frame_busy        (frame_busy),
        .frame_done        (frame_done),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_data          (pix_data),
        .drv_valid         (drv_valid),
        .drv_index_or_data (drv_index_or_data),
        .drv_data          (drv_data),
        .drv_done          (drv_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver responder and monitor: logs words, answers each with drv_done after 1..4 cycles.
    initial begin : drv_model
        bit outst;
        int lat;
        logic [8:0] held;
        outst = 1'b0;
        lat = 0;
        held = '0;
        forever begin
            @(negedge clk);
            drv_done = inject_done;
            if (!rstn) begin
                outst = 1'b0;
                drv_done = 1'b0;
                init_t = -1;
            end else begin
                if (frame_done) fd_cnt++;
                if (init_done && init_t < 0) init_t = cyc;
                if (outst) begin
                    if (drv_valid) ovl++;
                    if (drv_data !== held) unstable++;
                    if (lat == 0) begin
                        drv_done = 1'b1;
                        outst = 1'b0;
                        dt.push_back(cyc);
                    end else begin
                        lat--;
                    end
                end else if (drv_valid) begin
                    wlog.push_back(drv_data);
                    vt.push_back(cyc);
                    held = drv_data;
                    outst = 1'b1;
                    lat = 1 + (wlog.size() % 4);
                    if (drv_data[8] !== drv_index_or_data) dc_err++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("init_done_reached", 32'(init_done), 1);
    endtask

    task automatic wait_frame_end();
        int n = 0;
        while (frame_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("frame_end_reached", 32'(frame_busy), 0);
        @(negedge clk);
    endtask

    // Called just after a negedge; returns one negedge after the handshake edge.
    task automatic send_pix(input logic [15:0] d);
        int n = 0;
        pix_valid = 1'b1;
        pix_data = d;
        while (!pix_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        check("pix_handshake", 32'(n < 2000), 1);
    endtask

    task automatic pulse_frame_req();
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    task automatic pulse_start();
        start_init = 1'b1;
        @(negedge clk);
        start_init = 1'b0;
    endtask

    initial begin : stim
        int base;
        int nw;
        int fd0;
        int n;
        int rc;

        // 1: reset state, then ROM playback
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({drv_valid, drv_index_or_data, drv_data, init_done,
                                  frame_busy, frame_done, pix_ready}), 0);
        #2 rstn = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_init();
        @(negedge clk);
        check("rom_word_count", 32'(wlog.size()), 7);
        for (int i = 0; i < 7; i++) check("rom_word", 32'(wlog[i]), 32'(rom_exp[i]));
`ifdef LCD_SEQ_DELAY_EN
        check("gap_after_01", 32'((vt[1] - dt[0]) >= 600), 1);
        check("gap_after_11", 32'((vt[2] - dt[1]) >= 1020), 1);
`else
        check("gap_after_01", 32'((vt[1] - dt[0]) <= 8), 1);
        check("gap_after_11", 32'((vt[2] - dt[1]) <= 8), 1);
`endif
        check("init_after_last_done", 32'(init_t > dt[6]), 1);

        // 2 + 3: frame with a 50-cycle pix_valid pause after two pixels
        base = wlog.size();
        fd0 = fd_cnt;
        pulse_frame_req();
        check("busy_on_accept", 32'(frame_busy), 1);
        send_pix(16'h1234);
        send_pix(16'hABCD);
        n = 0;
        while (!pix_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        nw = wlog.size();
        rc = 0;
        repeat (50) begin
            @(negedge clk);
            if (pix_ready) rc++;
        end
        check("pause_no_strobe", 32'(wlog.size()), 32'(nw));
        check("pause_ready_held", 32'(rc), 50);
        send_pix(16'h0000);
        send_pix(16'hFFFF);
        wait_frame_end();
        check("frame1_word_count", 32'(wlog.size() - base), 19);
        for (int i = 0; i < 19; i++) check("frame1_word", 32'(wlog[base + i]), 32'(frm_exp[i]));
        check("frame1_done_pulses", 32'(fd_cnt - fd0), 1);

        // 4: stray drv_done and start_init in READY, frame_req while busy
        nw = wlog.size();
        #2 inject_done = 1'b1;
        @(negedge clk);
        #2 inject_done = 1'b0;
        @(negedge clk);
        pulse_start();
        repeat (20) @(negedge clk);
        check("ready_ignores_no_words", 32'(wlog.size()), 32'(nw));
        check("ready_state_kept", 32'({init_done, frame_busy, pix_ready}), 32'b100);
        base = wlog.size();
        fd0 = fd_cnt;
        pulse_frame_req();
        repeat (3) @(negedge clk);
        frame_req = 1'b1;
        start_init = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        start_init = 1'b0;
        for (int i = 0; i < 4; i++) send_pix(16'((2 * i + 1) << 8 | (2 * i + 2)));
        wait_frame_end();
        repeat (20) @(negedge clk);
        check("frame2_word_count", 32'(wlog.size() - base), 19);
        for (int i = 0; i < 8; i++)
            check("frame2_pix_byte", 32'(wlog[base + 11 + i]), 32'(9'h101 + i));
        check("frame2_done_pulses", 32'(fd_cnt - fd0), 1);
        check("frame2_idle_after", 32'({frame_busy, pix_ready}), 0);

        // 5: reset during the pixel high byte, then replay ROM
        pulse_frame_req();
        send_pix(16'h5A5A);
        @(negedge clk);
        check("hi_byte_in_flight", 32'(wlog[wlog.size() - 1]), 32'h15A);
        #2 rstn = 1'b0;
        #1 check("midreset_outputs", 32'({drv_valid, drv_index_or_data, drv_data, init_done,
                                            frame_busy, frame_done, pix_ready}), 0);
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", 32'({drv_valid, init_done, frame_busy, pix_ready}), 0);
        base = wlog.size();
        pulse_start();
        wait_init();
        @(negedge clk);
        check("replay_word_count", 32'(wlog.size() - base), 7);
        for (int i = 0; i < 7; i++) check("replay_word", 32'(wlog[base + i]), 32'(rom_exp[i]));

        check("no_overlapping_strobe", 32'(ovl), 0);
        check("word_stable_until_done", 32'(unstable), 0);
        check("dc_bit_matches", 32'(dc_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop so the run always terminates.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
